// File: rtl/led_sequencer_if.sv
// Control/status bundle between a register block (master) and one LED bank sequencer (slave).
interface led_sequencer_if #(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned DELAY_W = 4
);
    logic [DELAY_W-1:0] delay;
    logic [1:0]         mode;
    logic               dir;
    logic               pause;
    logic               step;
    logic [N_LEDS-1:0]  led;
    logic               running;
    logic               tick;

    modport master (
        output delay, mode, dir, pause, step,
        input  led, running, tick
    );

    modport slave (
        input  delay, mode, dir, pause, step,
        output led, running, tick
    );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern engine: bounce/rotate/fill/blink over N_LEDS with a prescaled step timer,
// edge-triggered pause toggle and single-step while paused.
module led_sequencer #(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned DELAY_W = 4,
    parameter int unsigned SHIFT   = 20
) (
    input  logic           clk,
    input  logic           reset,
    led_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = DELAY_W + SHIFT;
    localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dn_q, dn_d;
    logic              running_q, running_d;
    logic [1:0]        mode_q, mode_d;
    logic              pause_q, step_q;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              tick_q, tick_d;
    logic              advance;

    logic             pause_rise, step_rise;
    logic [CNT_W-1:0] reload;

    assign pause_rise = bus.pause & ~pause_q;
    assign step_rise  = bus.step & ~step_q;
    assign reload     = {bus.delay, {SHIFT{1'b0}}};

    // State register; pause/step are sampled during reset so a level held across reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            pos_q     <= '0;
            dn_q      <= 1'b0;
            running_q <= 1'b1;
            mode_q    <= bus.mode;
            pause_q   <= bus.pause;
            step_q    <= bus.step;
            led_q     <= N_LEDS'(1);
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pos_q     <= pos_d;
            dn_q      <= dn_d;
            running_q <= running_d;
            mode_q    <= mode_d;
            pause_q   <= bus.pause;
            step_q    <= bus.step;
            led_q     <= led_d;
            tick_q    <= tick_d;
        end
    end

    // Next state: mode change > pause rise > step rise > timer.
    always_comb begin
        count_d   = count_q;
        pos_d     = pos_q;
        dn_d      = dn_q;
        running_d = running_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;
        advance   = 1'b0;

        if (bus.mode != mode_q) begin
            mode_d  = bus.mode;
            pos_d   = '0;
            dn_d    = 1'b0;
            count_d = '0;
        end else if (pause_rise) begin
            running_d = ~running_q;
        end else if (step_rise) begin
            advance = ~running_q;
        end else if (running_q) begin
            if (count_q == '0) begin
                count_d = reload;
                advance = 1'b1;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end

        if (advance) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dn_q) begin
                        pos_d = pos_q - POS_W'(1);
                        if (pos_q == POS_W'(1)) dn_d = 1'b0;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                        if (pos_q == POS_W'(N_LEDS - 2)) dn_d = 1'b1;
                    end
                end
                MODE_ROTATE: begin
                    if (bus.dir) begin
                        pos_d = (pos_q == '0) ? POS_W'(N_LEDS - 1) : pos_q - POS_W'(1);
                    end else begin
                        pos_d = (pos_q == POS_W'(N_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
                    end
                end
                MODE_FILL: begin
                    pos_d = (pos_q == POS_W'(N_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
                end
                default: begin
                    pos_d = (pos_q == '0) ? POS_W'(1) : '0;
                end
            endcase
        end
    end

    // Pattern decode from the next mode/position so led lines up with tick.
    always_comb begin
        led_d = '0;
        case (mode_d)
            MODE_FILL: begin
                for (int i = 0; i < int'(N_LEDS); i++) led_d[i] = (POS_W'(i) <= pos_d);
            end
            MODE_BLINK: begin
                led_d = pos_d[0] ? '0 : '1;
            end
            default: begin
                for (int i = 0; i < int'(N_LEDS); i++) led_d[i] = (POS_W'(i) == pos_d);
            end
        endcase
    end

    assign bus.led     = led_q;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (N_LEDS=8, DELAY_W=4, SHIFT=2) with hand-computed expectations.
module tb_led_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    led_sequencer_if #(.N_LEDS(8), .DELAY_W(4)) bus ();

    led_sequencer #(.N_LEDS(8), .DELAY_W(4), .SHIFT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] BOUNCE_EXP [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    localparam logic [7:0] FILL_EXP [8] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; outputs are then stable 1 time unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait out 4 quiet cycles of a period-5 step, then check the tick cycle's pattern.
    task automatic next_tick(input string tag, input logic [7:0] exp_led);
        for (int j = 0; j < 4; j++) begin
            cyc(1);
            check({tag, " quiet"}, 32'(bus.tick), 32'(0));
        end
        cyc(1);
        check({tag, " tick"}, 32'(bus.tick), 32'(1));
        check({tag, " led"}, 32'(bus.led), 32'(exp_led));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        bus.mode  = 2'd0;
        bus.delay = 4'd1;
        bus.dir   = 1'b0;
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        cyc(3);
        check("reset led", 32'(bus.led), 32'h01);
        check("reset running", 32'(bus.running), 32'(1));
        check("reset tick", 32'(bus.tick), 32'(0));

        // T1: bounce, first tick on the first cycle out of reset, then every 5 cycles
        reset = 1'b0;
        cyc(1);
        check("t1 first tick", 32'(bus.tick), 32'(1));
        check("t1 first led", 32'(bus.led), 32'(BOUNCE_EXP[0]));
        for (int k = 1; k < 15; k++) next_tick($sformatf("t1 step%0d", k), BOUNCE_EXP[k]);

        // T2: rotate down at full speed, then reverse
        bus.mode  = 2'd1;
        bus.dir   = 1'b1;
        bus.delay = 4'd0;
        cyc(1);
        check("t2 modechg led", 32'(bus.led), 32'h01);
        check("t2 modechg tick", 32'(bus.tick), 32'(0));
        cyc(1);
        check("t2 down1 led", 32'(bus.led), 32'h80);
        check("t2 down1 tick", 32'(bus.tick), 32'(1));
        cyc(1);
        check("t2 down2 led", 32'(bus.led), 32'h40);
        bus.dir = 1'b0;
        cyc(1);
        check("t2 up1 led", 32'(bus.led), 32'h80);
        cyc(1);
        check("t2 up2 led", 32'(bus.led), 32'h01);

        // T3: fill then blink
        bus.mode = 2'd2;
        cyc(1);
        check("t3 fill start", 32'(bus.led), 32'h01);
        check("t3 fill start tick", 32'(bus.tick), 32'(0));
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check($sformatf("t3 fill%0d", k), 32'(bus.led), 32'(FILL_EXP[k]));
        end
        bus.mode = 2'd3;
        cyc(1);
        check("t3 blink start", 32'(bus.led), 32'hFF);
        cyc(1);
        check("t3 blink off", 32'(bus.led), 32'h00);
        cyc(1);
        check("t3 blink on", 32'(bus.led), 32'hFF);
        cyc(1);
        check("t3 blink off2", 32'(bus.led), 32'h00);

        // T4: pause, freeze, single step, pause+step together, resume with held count
        bus.mode  = 2'd1;
        bus.dir   = 1'b0;
        bus.delay = 4'd1;
        cyc(1);
        check("t4 modechg led", 32'(bus.led), 32'h01);
        cyc(1);
        check("t4 tick", 32'(bus.tick), 32'(1));
        check("t4 led", 32'(bus.led), 32'h02);
        bus.pause = 1'b1;
        cyc(1);
        check("t4 paused", 32'(bus.running), 32'(0));
        check("t4 pause tick", 32'(bus.tick), 32'(0));
        bus.pause = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(10);
            check($sformatf("t4 frozen%0d", k), 32'(bus.led), 32'h02);
        end
        bus.step = 1'b1;
        cyc(1);
        check("t4 step led", 32'(bus.led), 32'h04);
        check("t4 step tick", 32'(bus.tick), 32'(0));
        bus.step = 1'b0;
        cyc(1);
        check("t4 step once", 32'(bus.led), 32'h04);
        bus.pause = 1'b1;
        bus.step  = 1'b1;
        cyc(1);
        check("t4 both running", 32'(bus.running), 32'(1));
        check("t4 both led", 32'(bus.led), 32'h04);
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        next_tick("t4 resume", 8'h08);

        // T5: mode change at pos=5 restarts the pattern and timer
        next_tick("t5 pos4", 8'h10);
        next_tick("t5 pos5", 8'h20);
        bus.mode = 2'd2;
        cyc(1);
        check("t5 modechg led", 32'(bus.led), 32'h01);
        check("t5 modechg tick", 32'(bus.tick), 32'(0));
        cyc(1);
        check("t5 tick", 32'(bus.tick), 32'(1));
        check("t5 led", 32'(bus.led), 32'h03);

        // T6: reset while paused at pos=3 with pause level held
        bus.mode = 2'd1;
        cyc(2);
        check("t6 pos1", 32'(bus.led), 32'h02);
        bus.pause = 1'b1;
        cyc(1);
        check("t6 paused", 32'(bus.running), 32'(0));
        for (int k = 0; k < 2; k++) begin
            bus.step = 1'b1;
            cyc(1);
            bus.step = 1'b0;
            cyc(1);
        end
        check("t6 pos3", 32'(bus.led), 32'h08);
        reset = 1'b1;
        cyc(1);
        check("t6 reset led", 32'(bus.led), 32'h01);
        check("t6 reset running", 32'(bus.running), 32'(1));
        reset = 1'b0;
        cyc(1);
        check("t6 no toggle", 32'(bus.running), 32'(1));
        check("t6 tick", 32'(bus.tick), 32'(1));
        check("t6 led", 32'(bus.led), 32'h02);
        cyc(1);
        check("t6 still running", 32'(bus.running), 32'(1));
        bus.pause = 1'b0;
        cyc(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
